// File: rtl/output_gain.sv
// Master-volume and saturation stage ahead of the delta-sigma DAC: serial shift-add
// gain (volume/16), floor shift, 14-bit saturation. Optional: OUTPUT_GAIN_VOLUME_RAMP_EN.
module output_gain #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14,
  parameter int SHIFT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_valid_i,
  input  logic signed [IN_W-1:0]  sample_i,
  input  logic [3:0]              volume_i,
  output logic                    ready_o,
  output logic                    audio_valid_o,
  output logic signed [OUT_W-1:0] audio_o,
  output logic                    overrun_o,
  input  logic                    overrun_clr_i
);

  localparam int ACC_W = IN_W + 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SAT} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [IN_W-1:0]   r_sample;
  logic [3:0]               r_vol;
  logic signed [ACC_W-1:0]  r_acc;
  logic [1:0]               r_bit_cnt;
  logic signed [OUT_W-1:0]  r_audio;
  logic                     r_audio_valid;
  logic                     r_overrun;

  logic [3:0]               w_vol_cap;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_addend;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [OUT_W-1:0]  w_sat;

`ifdef OUTPUT_GAIN_VOLUME_RAMP_EN
  // Effective volume moves one step per captured sample toward volume_i.
  logic [3:0] r_eff_vol;

  always_comb begin
    w_vol_cap = r_eff_vol;
    if (r_eff_vol < volume_i)      w_vol_cap = r_eff_vol + 4'd1;
    else if (r_eff_vol > volume_i) w_vol_cap = r_eff_vol - 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 r_eff_vol <= '0;
    else if (r_state == S_IDLE && sample_valid_i) r_eff_vol <= w_vol_cap;
  end
`else
  assign w_vol_cap = volume_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (sample_valid_i) w_state_nxt = S_MUL;
      S_MUL:   if (r_bit_cnt == 2'd3) w_state_nxt = S_SAT;
      S_SAT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ext    = {{(ACC_W-IN_W){r_sample[IN_W-1]}}, r_sample};
  assign w_addend = w_ext <<< r_bit_cnt;

  // Arithmetic shift gives floor rounding for negative products.
  assign w_shifted = r_acc >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[OUT_W-1:0];
    if (w_shifted > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_shifted < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers
  // are reset too so an aborted sample leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sample      <= '0;
      r_vol         <= '0;
      r_acc         <= '0;
      r_bit_cnt     <= '0;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_audio_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (sample_valid_i) begin
            r_sample  <= sample_i;
            r_vol     <= w_vol_cap;
            r_acc     <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_MUL: begin
          if (r_vol[r_bit_cnt]) r_acc <= r_acc + w_addend;
          r_bit_cnt <= r_bit_cnt + 2'd1;
        end
        S_SAT: begin
          r_audio       <= w_sat;
          r_audio_valid <= 1'b1;
        end
        default: ;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (sample_valid_i && r_state != S_IDLE) r_overrun <= 1'b1;
      else if (overrun_clr_i)                  r_overrun <= 1'b0;
    end
  end

  assign ready_o       = (r_state == S_IDLE);
  assign audio_valid_o = r_audio_valid;
  assign audio_o       = r_audio;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_output_gain.sv
// Scoreboard bench for output_gain: the driver queues expected samples and due cycles,
// a negedge monitor pops and compares on every audio_valid_o strobe.
module tb_output_gain;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               sample_valid_i = 1'b0;
  logic signed [15:0] sample_i = '0;
  logic [3:0]         volume_i = '0;
  logic               ready_o;
  logic               audio_valid_o;
  logic signed [13:0] audio_o;
  logic               overrun_o;
  logic               overrun_clr_i = 1'b0;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  output_gain dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .volume_i       (volume_i),
    .ready_o        (ready_o),
    .audio_valid_o  (audio_valid_o),
    .audio_o        (audio_o),
    .overrun_o      (overrun_o),
    .overrun_clr_i  (overrun_clr_i)
  );

  always #10 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && audio_valid_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: strobe with audio_o=%0d, expected none (cycle %0d)",
                 audio_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("audio_value", int'(audio_o), e.val);
        check("audio_latency", cyc, e.due);
      end
    end
  end

  // Waits for ready_o, issues one strobe; returns just after the capture edge.
  task automatic send(input logic signed [15:0] s, input logic [3:0] v,
                      input int exp_val, input bit expect_out);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) check("ready_timeout", int'(ready_o), 1);
    sample_i       = s;
    volume_i       = v;
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    if (expect_out) begin
      e.val = exp_val;
      e.due = cyc + 5;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_ready", int'(ready_o), 1);
    check("reset_valid", int'(audio_valid_o), 0);
    check("reset_audio", int'(audio_o), 0);
    check("reset_overrun", int'(overrun_o), 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

`ifdef OUTPUT_GAIN_VOLUME_RAMP_EN
    for (int k = 1; k <= 17; k++) begin
      send(16'sd1600, 4'd15, (k <= 15) ? 100 * k : 1500, 1'b1);
    end
    drain();
`else
    // Volume change right after capture must not affect the sample in flight.
    send(16'sd1000, 4'd15, 937, 1'b1);
    volume_i = 4'd0;
    drain();
    send(-16'sd1000, 4'd15, -938, 1'b1);
    send(16'sd12345, 4'd0, 0, 1'b1);
    send(16'sd32767, 4'd15, 8191, 1'b1);
    send(-16'sd32768, 4'd15, -8192, 1'b1);
    drain();
    repeat (5) @(negedge clk_i);
    check("audio_hold", int'(audio_o), -8192);

    // Drop: second strobe two cycles after the first.
    send(16'sd1000, 4'd15, 937, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    sample_i = 16'sd5000;
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    check("overrun_set", int'(overrun_o), 1);
    drain();
    repeat (3) @(negedge clk_i);
    check("overrun_sticky", int'(overrun_o), 1);

    // Set and clear in the same cycle: set wins.
    send(16'sd2000, 4'd8, 1000, 1'b1);
    @(negedge clk_i);
    sample_valid_i = 1'b1;
    overrun_clr_i  = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    overrun_clr_i  = 1'b0;
    check("overrun_set_wins", int'(overrun_o), 1);
    drain();

    @(negedge clk_i);
    overrun_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    overrun_clr_i = 1'b0;
    check("overrun_clear", int'(overrun_o), 0);

    // Reset two cycles after capture: no strobe, outputs back to reset values.
    send(16'sd3000, 4'd15, 0, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midreset_ready", int'(ready_o), 1);
    check("midreset_audio", int'(audio_o), 0);
    check("midreset_valid", int'(audio_valid_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);

    send(16'sd100, 4'd7, 43, 1'b1);
    send(-16'sd100, 4'd7, -44, 1'b1);
    drain();
`endif

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/output_gain.md
Name: output_gain

Overview:
Master-volume and saturation stage that sits directly upstream of the delta-sigma DAC. It accepts wide signed mixer samples and multiplies each one by a 4-bit master volume using a serial shift-add multiplier. It then scales and saturates the result to 14-bit signed and presents it with a single-cycle valid pulse that the DAC samples into its hold register. Runs on the 50 MHz system clock; sample rate (~48 kHz) is set by the upstream mixer.

Parameters:
IN_W, 16, width of signed input sample.
OUT_W, 14, width of signed output sample (matches DAC input).
SHIFT, 4, arithmetic right shift applied to the product before saturation (gain = volume/16).

Ports:
clk_i  input  1  system clock, 50 MHz.
rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
sample_valid_i  input  1  single-cycle strobe, sample_i valid.
sample_i  input  IN_W  signed mixer sample.
volume_i  input  4  unsigned master volume 0..15.
ready_o  output  1  high when a new sample can be accepted.
audio_valid_o  output  1  single-cycle strobe, audio_o updated (to DAC audio_valid_i).
audio_o  output  OUT_W  signed saturated sample (to DAC audio_i).
overrun_o  output  1  sticky, a sample was dropped.
overrun_clr_i  input  1  clears overrun_o.

Behaviour:
- Reset values:
  - State IDLE; ready_o=1; audio_valid_o=0; audio_o=0; overrun_o=0.
  - Accumulator, multiplicand and bit counter cleared.
- FSM states: IDLE, MUL, SAT.
  - ready_o = (state==IDLE), decoded combinationally from the state register.
- Capture at edge E0:
  - Condition: IDLE and sample_valid_i=1.
  - Registers sample_i and the effective volume (see Optional Feature); clears the accumulator and bit counter; state->MUL.
- MUL, edges E1..E4:
  - One volume bit per edge, LSB first.
  - If the bit is set, the accumulator adds (sample << bit index).
  - Accumulator is IN_W+5 bits signed, so no overflow is possible.
  - At E4, state->SAT.
- SAT, edge E5:
  - audio_o <= sat(acc >>> SHIFT) to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Shift is arithmetic, i.e. floor rounding.
  - audio_valid_o=1 for exactly the cycle following E5; state->IDLE.
- Latency and rate:
  - audio_valid_o is high 5 edges after the capture edge.
  - Next capture is possible at E6 at the earliest, so the minimum input spacing is 6 cycles.
- audio_o holds its value between strobes.
- Inputs are sampled only at capture; volume_i changes mid-operation do not affect the sample in flight.
- Overrun:
  - sample_valid_i=1 while not IDLE drops that sample and sets overrun_o=1.
  - Processing of the in-flight sample is unaffected.
  - overrun_clr_i clears overrun_o.
  - If set and clear occur in the same cycle, set wins.
- Volume 0: the full sequence still runs and audio_o=0 with a valid strobe.
- Reset mid-operation: immediate return to reset values; no audio_valid_o pulse is issued for the aborted sample.

Optional Feature:
- Macro: OUTPUT_GAIN_VOLUME_RAMP_EN.
- Defined:
  - An effective-volume register (reset 0) steps by ±1 toward volume_i at each capture edge.
  - The stepped value is the multiplier for that sample.
  - If equal to volume_i, it is unchanged.
  - This limits zipper noise to at most one step per sample.
- Undefined: volume_i is used directly at capture; no effective-volume register exists.

Test Plan:
- volume_i=15, sample_i=1000 -> audio_valid_o pulse 5 edges after capture, audio_o=937.
- volume_i=15, sample_i=-1000 -> audio_o=-938 (floor); volume_i=0, sample_i=12345 -> audio_o=0, strobe still issued.
- volume_i=15, sample_i=32767 -> audio_o=8191; sample_i=-32768 -> audio_o=-8192 (saturation both rails).
- Second sample_valid_i pulse 2 cycles after the first -> exactly one audio_valid_o, overrun_o=1. Same-cycle overrun_clr_i with a new drop -> overrun_o stays 1. Clear alone -> 0.
- rst_ni asserted 2 cycles after capture -> no audio_valid_o, audio_o=0, ready_o=1 immediately.
- With OUTPUT_GAIN_VOLUME_RAMP_EN, after reset volume_i=15, constant sample_i=1600 -> successive audio_o 100, 200, 300 … 1500, then 1500 steady.
